// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types for the instruction-fetch stage
package fetch_stage_pkg;
  typedef logic [31:0] word_t;
  typedef word_t addr_t;
  typedef struct packed {
    word_t pc;
    word_t instruction;
  } fetch_data_t;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_next.sv
// fetch_stage_pc_next: next-PC select, redirect over sequential advance over hold
module fetch_stage_pc_next
  import fetch_stage_pkg::*;
(
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  input  logic  advance,
  input  addr_t pc,
  output addr_t pc_next
);
  always_comb pc_next = redirect_valid ? {redirect_pc[31:2], 2'b00} : advance ? pc + 32'd4 : pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one ibus read at a time, holds the word for decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter addr_t RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ibus_valid,
  output addr_t       ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  word_t       ibus_data,
  input  logic        redirect_valid,
  input  addr_t       redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output fetch_data_t fetch_data
);
  fetch_state_t state, state_n;
  logic drop, drop_n, capture;
  addr_t pc, pc_n;
  fetch_stage_pc_next u_pc_next (
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .advance(state == S_HOLD && fetch_ready),
    .pc(pc),
    .pc_next(pc_n)
  );
  always_comb begin
    state_n = state;
    drop_n = drop;
    capture = 1'b0;
    case (state)
      S_REQ: begin
        state_n = ibus_addr_ok ? S_WAIT : S_REQ;
        drop_n = ibus_addr_ok && redirect_valid;
      end
      S_WAIT: begin
        state_n = !ibus_data_ok ? S_WAIT : (drop || redirect_valid) ? S_REQ : S_HOLD;
        drop_n = !ibus_data_ok && (drop || redirect_valid);
        capture = ibus_data_ok && !drop && !redirect_valid;
      end
      S_HOLD: state_n = (fetch_ready || redirect_valid) ? S_REQ : S_HOLD;
      default: state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc <= RESET_PC;
      state <= S_REQ;
      drop <= 1'b0;
      fetch_data <= '0;
    end else begin
      pc <= pc_n;
      state <= state_n;
      drop <= drop_n;
      if (capture) fetch_data <= '{pc: pc, instruction: ibus_data};
    end
  end
  assign ibus_valid = resetn && state == S_REQ;
  assign ibus_addr = pc;
  assign fetch_valid = resetn && state == S_HOLD;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random bus/redirect stimulus with a PC-stream scoreboard
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  localparam addr_t RESET_PC = 32'hBFC0_0000;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ibus_valid, ibus_addr_ok = 1'b0, ibus_data_ok = 1'b0;
  addr_t ibus_addr;
  word_t ibus_data = '0;
  logic redirect_valid = 1'b0;
  addr_t redirect_pc = '0;
  logic fetch_valid, fetch_ready = 1'b0;
  fetch_data_t fetch_data;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  fetch_data_t exp_q[$];
  addr_t exp_pc = RESET_PC;
  logic pending = 1'b0;
  addr_t paddr = '0;
  int unsigned lat = 0;
  logic prev_req = 1'b0, prev_hold = 1'b0;
  addr_t prev_addr = '0;
  fetch_data_t prev_fd = '0;
  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .resetn(resetn),
    .ibus_valid(ibus_valid),
    .ibus_addr(ibus_addr),
    .ibus_addr_ok(ibus_addr_ok),
    .ibus_data_ok(ibus_data_ok),
    .ibus_data(ibus_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_data(fetch_data)
  );
  always #5 clk = ~clk;
  function automatic word_t mem(addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction
  function automatic fetch_data_t expect_at(addr_t a);
    fetch_data_t f;
    f.pc = a;
    f.instruction = mem(a);
    return f;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      resetn = cyc >= 2 && $urandom_range(0, 299) != 0;
      #1;
      redirect_valid = resetn && $urandom_range(0, 19) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 3)) : $urandom;
      fetch_ready = $urandom_range(0, 9) < 7;
      ibus_addr_ok = resetn && ibus_valid && !pending && $urandom_range(0, 2) != 0;
      ibus_data_ok = resetn && pending && lat == 0;
      ibus_data = ibus_data_ok ? mem(paddr) : $urandom;
    end
    @(negedge clk);
    chk("deliveries_seen", 64'(delivered > 200), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_ibus_valid", 64'(ibus_valid), 64'd0);
      chk("reset_fetch_valid", 64'(fetch_valid), 64'd0);
      exp_pc = RESET_PC;
      exp_q.delete();
      exp_q.push_back(expect_at(RESET_PC));
      pending = 1'b0;
      prev_req = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_req) begin
        chk("req_held_valid", 64'(ibus_valid), 64'd1);
        chk("req_held_addr", 64'(ibus_addr), 64'(prev_addr));
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(fetch_valid), 64'd1);
        chk("hold_data", fetch_data, prev_fd);
      end
      if (ibus_valid) chk("single_outstanding", {62'd0, pending, fetch_valid}, 64'd0);
      if (ibus_data_ok) pending = 1'b0;
      else if (pending && lat > 0) lat--;
      if (ibus_valid && ibus_addr_ok) begin
        chk("req_addr", 64'(ibus_addr), 64'(exp_pc));
        pending = 1'b1;
        paddr = ibus_addr;
        lat = $urandom_range(0, 2);
      end
      if (fetch_valid && fetch_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver: got %h expected nothing", fetch_data);
        end else chk("deliver", fetch_data, exp_q.pop_front());
        delivered++;
        exp_pc = exp_pc + 32'd4;
        exp_q.delete();
        exp_q.push_back(expect_at(exp_pc));
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
        exp_q.delete();
        exp_q.push_back(expect_at(exp_pc));
      end
      prev_req = ibus_valid && !ibus_addr_ok && !redirect_valid;
      prev_addr = ibus_addr;
      prev_hold = fetch_valid && !fetch_ready && !redirect_valid;
      prev_fd = fetch_data;
    end
  end
endmodule
